// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-per-line instruction cache.
// Hits answer one cycle after the request; misses fetch one word from the
// memory controller, fill the line and forward the word.
// Optional feature: define ICACHE_PERF_EN for the hit_cnt/miss_cnt counters.
module icache_direct_mapped #(
  parameter int LINE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        fet_ena,
  output logic [31:0] instr_addr,
  input  logic        valid_from_mc,
  input  logic [31:0] data_from_mc
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << LINE_BITS;
  localparam int TAG_W = 30 - LINE_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]          data_ram [LINES];
  logic [TAG_W-1:0]     tag_ram  [LINES];
  logic [LINES-1:0]     valid_q;

  logic [LINE_BITS-1:0] req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [LINE_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 lookup_hit;

  logic do_hit;   // accepted lookup that hits
  logic do_miss;  // accepted lookup that misses
  logic do_fill;  // memory word arrives for the outstanding miss
  logic do_resp;  // forward the arriving word to the fetcher

  assign req_idx    = fetch_pc[LINE_BITS+1:2];
  assign req_tag    = fetch_pc[31:LINE_BITS+2];
  assign fill_idx   = instr_addr[LINE_BITS+1:2];
  assign fill_tag   = instr_addr[31:LINE_BITS+2];
  assign lookup_hit = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);

  // State register; rdy=0 freezes the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state_q <= S_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state and per-cycle action decode
  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    do_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush beats a simultaneous request; stray MC pulses are ignored here
        if (fetch_req && !flush) begin
          if (lookup_hit) begin
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_d = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (valid_from_mc) begin
          do_fill = 1'b1;
          do_resp = !flush;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (valid_from_mc) begin
          do_fill = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetcher response and memory-controller request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_out   <= '0;
      fet_ena     <= 1'b0;
      instr_addr  <= '0;
    end else if (rdy) begin
      instr_valid <= do_hit || do_resp;
      if (do_hit)  instr_out <= data_ram[req_idx];
      if (do_resp) instr_out <= data_from_mc;
      if (do_miss) begin
        fet_ena    <= 1'b1;
        instr_addr <= fetch_pc & ~32'h3;
      end
      if (do_fill) fet_ena <= 1'b0;
    end
  end

  // Valid bits: cleared only by reset, set on every fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  valid_q <= '0;
    else if (rdy && do_fill)  valid_q[fill_idx] <= 1'b1;
  end

  // Data and tag storage; contents are qualified by valid_q so need no reset
  always_ff @(posedge clk) begin
    if (rdy && do_fill) begin
      data_ram[fill_idx] <= data_from_mc;
      tag_ram[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  // Hit/miss counters over accepted (non-flushed) IDLE lookups
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (do_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped against a line-map model.
// Build with ICACHE_PERF_EN defined to also check the performance counters.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        fet_ena;
  logic [31:0] instr_addr;
  logic        valid_from_mc = 1'b0;
  logic [31:0] data_from_mc = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: which word address currently lives in each line
  logic [29:0] m_addr [int];
  logic [31:0] m_data [int];

  icache_direct_mapped #(.LINE_BITS(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
    .instr_valid(instr_valid), .instr_out(instr_out),
    .fet_ena(fet_ena), .instr_addr(instr_addr),
    .valid_from_mc(valid_from_mc), .data_from_mc(data_from_mc)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_addr.exists(line_of(pc)) && (m_addr[line_of(pc)] == pc[31:2]);
  endfunction

  task automatic m_fill(input logic [31:0] pc, input logic [31:0] d);
    m_addr[line_of(pc)] = pc[31:2];
    m_data[line_of(pc)] = d;
  endtask

  task automatic do_reset();
    fetch_req = 1'b0; flush = 1'b0; valid_from_mc = 1'b0; rdy = 1'b1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_addr.delete();
    m_data.delete();
    step();
  endtask

  // One fetcher transaction; the memory controller answers after lat idle cycles
  task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] mc_data,
                       output bit hit, output bit vseen, output logic [31:0] word,
                       output bit hs_ok, output bit pulse_ok);
    logic [31:0] a0;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    step();
    if (instr_valid === 1'b1) begin
      hit = 1'b1; vseen = 1'b1; word = instr_out;
      hs_ok = (fet_ena === 1'b0);
      fetch_req = 1'b0;
    end else begin
      hit = 1'b0;
      a0 = instr_addr;
      hs_ok = (fet_ena === 1'b1) && (instr_addr === {pc[31:2], 2'b00});
      for (int i = 0; i < lat; i++) begin
        step();
        hs_ok &= (fet_ena === 1'b1) && (instr_addr === a0) && (instr_valid === 1'b0);
      end
      valid_from_mc = 1'b1;
      data_from_mc  = mc_data;
      step();
      valid_from_mc = 1'b0;
      fetch_req = 1'b0;
      vseen = (instr_valid === 1'b1);
      word  = instr_out;
      hs_ok &= (fet_ena === 1'b0);
    end
    step();
    pulse_ok = (instr_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", instr_out); end
    total++; if (fet_ena !== 1'b0) begin bad++; $display("FAIL reset_fet_ena got=%b want=0", fet_ena); end
    total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", instr_addr); end
    do_reset();
  endtask

  task automatic test_directed();
    bit h, v, ok, p;
    logic [31:0] w;
    logic [31:0] pcs [4] = '{32'h0, 32'h0, 32'h400, 32'h0};
    logic [31:0] ds  [4] = '{32'h13, 32'hdead_0000, 32'h0000_4413, 32'h0000_0113};
    bit          eh  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ew;
    for (int i = 0; i < 4; i++) begin
      ew = eh[i] ? m_data[line_of(pcs[i])] : ds[i];
      fetch(pcs[i], 2, ds[i], h, v, w, ok, p);
      if (!eh[i]) m_fill(pcs[i], ds[i]);
      total++; if (h !== eh[i]) begin bad++; $display("FAIL dir_hit[%0d] got=%b want=%b", i, h, eh[i]); end
      total++; if (!v || w !== ew) begin bad++; $display("FAIL dir_word[%0d] got=%h want=%h", i, w, ew); end
      total++; if (!ok) begin bad++; $display("FAIL dir_handshake[%0d] got=0 want=1", i); end
      total++; if (!p) begin bad++; $display("FAIL dir_pulse[%0d] got=1 want=0", i); end
    end
`ifdef ICACHE_PERF_EN
    total++; if (hit_cnt !== 32'd1) begin bad++; $display("FAIL perf_hit got=%0d want=1", hit_cnt); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL perf_miss got=%0d want=3", miss_cnt); end
`endif
  endtask

  task automatic test_flush_miss();
    bit h, v, ok, p;
    logic [31:0] w;
    logic [31:0] d = 32'h1234_5678;
    fetch_req = 1'b1; fetch_pc = 32'h10;
    step();
    total++; if (fet_ena !== 1'b1) begin bad++; $display("FAIL flush_start got=%b want=1", fet_ena); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++; if (fet_ena !== 1'b1 || instr_addr !== 32'h10) begin bad++; $display("FAIL flush_hold got=%b/%h want=1/00000010", fet_ena, instr_addr); end
    valid_from_mc = 1'b1; data_from_mc = d;
    step();
    valid_from_mc = 1'b0;
    m_fill(32'h10, d);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_noresp got=%b want=0", instr_valid); end
    total++; if (fet_ena !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", fet_ena); end
    fetch(32'h10, 1, 32'hbad0_bad0, h, v, w, ok, p);
    total++; if (h !== 1'b1 || w !== d) begin bad++; $display("FAIL flush_refetch got=%b/%h want=1/%h", h, w, d); end
  endtask

  task automatic test_flush_same_cycle();
    bit h, v, ok, p;
    logic [31:0] w;
    logic [31:0] pc = 32'h0001_5424;
    logic [31:0] d  = 32'h0bad_cafe;
    fetch_req = 1'b1; fetch_pc = pc;
    step();
    flush = 1'b1; valid_from_mc = 1'b1; data_from_mc = d;
    step();
    flush = 1'b0; valid_from_mc = 1'b0; fetch_req = 1'b0;
    m_fill(pc, d);
    total++; if (instr_valid !== 1'b0 || fet_ena !== 1'b0) begin bad++; $display("FAIL flushfill_resp got=%b/%b want=0/0", instr_valid, fet_ena); end
    step();
    fetch(pc, 1, 32'h1, h, v, w, ok, p);
    total++; if (h !== 1'b1 || w !== d) begin bad++; $display("FAIL flushfill_hit got=%b/%h want=1/%h", h, w, d); end
  endtask

  task automatic test_idle_flush();
`ifdef ICACHE_PERF_EN
    logic [31:0] hc = hit_cnt, mc = miss_cnt;
`endif
    fetch_req = 1'b1; fetch_pc = 32'h10; flush = 1'b1;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    total++; if (instr_valid !== 1'b0 || fet_ena !== 1'b0) begin bad++; $display("FAIL idleflush got=%b/%b want=0/0", instr_valid, fet_ena); end
    fetch_req = 1'b1; fetch_pc = 32'h0007_7700; flush = 1'b1;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    total++; if (fet_ena !== 1'b0) begin bad++; $display("FAIL idleflush_miss got=%b want=0", fet_ena); end
`ifdef ICACHE_PERF_EN
    total++; if (hit_cnt !== hc || miss_cnt !== mc) begin bad++; $display("FAIL idleflush_perf got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, hc, mc); end
`endif
  endtask

  task automatic test_spurious();
    valid_from_mc = 1'b1; data_from_mc = 32'hffff_ffff;
    step();
    valid_from_mc = 1'b0;
    total++; if (instr_valid !== 1'b0 || fet_ena !== 1'b0) begin bad++; $display("FAIL spurious got=%b/%b want=0/0", instr_valid, fet_ena); end
  endtask

  task automatic test_rdy_pause();
    logic [31:0] pc = 32'h0002_a0c8;
    logic [31:0] d  = 32'h5a5a_0001;
    fetch_req = 1'b1; fetch_pc = pc;
    step();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_pc = $urandom;
      step();
      total++; if (fet_ena !== 1'b1 || instr_addr !== {pc[31:2], 2'b00} || instr_valid !== 1'b0) begin
        bad++; $display("FAIL pause[%0d] got=%b/%h/%b want=1/%h/0", i, fet_ena, instr_addr, instr_valid, {pc[31:2], 2'b00});
      end
    end
    rdy = 1'b1; fetch_pc = pc;
    step();
    valid_from_mc = 1'b1; data_from_mc = d;
    step();
    valid_from_mc = 1'b0; fetch_req = 1'b0;
    m_fill(pc, d);
    total++; if (instr_valid !== 1'b1 || instr_out !== d || fet_ena !== 1'b0) begin bad++; $display("FAIL pause_resume got=%b/%h/%b want=1/%h/0", instr_valid, instr_out, fet_ena, d); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a = 32'h10, b = 32'h0002_a0c8;
    fetch_req = 1'b1; fetch_pc = a;
    step();
    total++; if (instr_valid !== 1'b1 || instr_out !== m_data[line_of(a)]) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", instr_valid, instr_out, m_data[line_of(a)]); end
    fetch_pc = b;
    step();
    total++; if (instr_valid !== 1'b1 || instr_out !== m_data[line_of(b)]) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/%h", instr_valid, instr_out, m_data[line_of(b)]); end
    fetch_req = 1'b0;
    step();
    total++; if (instr_valid !== 1'b0 || instr_out !== m_data[line_of(b)]) begin bad++; $display("FAIL b2b_hold got=%b/%h want=0/%h", instr_valid, instr_out, m_data[line_of(b)]); end
  endtask

  task automatic test_random();
    bit h, v, ok, p, eh;
    logic [31:0] w, pc, d, ew;
    for (int n = 0; n < 80; n++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      d  = $urandom;
      eh = m_hit(pc);
      ew = eh ? m_data[line_of(pc)] : d;
      fetch(pc, $urandom_range(0, 3), d, h, v, w, ok, p);
      if (!eh) m_fill(pc, d);
      total++; if (h !== eh || !v || w !== ew || !ok || !p) begin
        bad++; $display("FAIL rand[%0d] pc=%h got hit=%b v=%b w=%h hs=%b pulse=%b want hit=%b w=%h", n, pc, h, v, w, ok, p, eh, ew);
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    bit h, v, ok, p;
    logic [31:0] w;
    fetch_req = 1'b1; fetch_pc = 32'h0003_3300;
    step();
    #2 rst = 1'b1;
    #1;
    total++; if (fet_ena !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL midrst got=%b/%b want=0/0", fet_ena, instr_valid); end
    fetch_req = 1'b0;
    #1 rst = 1'b0;
    m_addr.delete();
    m_data.delete();
    step();
    fetch(32'h0, 1, 32'h77, h, v, w, ok, p);
    total++; if (h !== 1'b0 || w !== 32'h77 || !ok) begin bad++; $display("FAIL midrst_miss got=%b/%h want=0/00000077", h, w); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_miss();
    test_flush_same_cycle();
    test_idle_flush();
    test_spurious();
    test_rdy_pause();
    test_back_to_back();
    test_random();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
